// File: rtl/rs_dec_out_framer_pkg.sv
// Shared definitions for the RS decoder output framer: FSM states, frame geometry
// and the layout of a buffered entry {abort, eop, sop, data}.
package rs_dec_out_framer_pkg;

  typedef enum logic [1:0] {
    ST_HUNT,
    ST_DATA,
    ST_PARITY,
    ST_SKIP
  } frm_state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic int k_num(input int n, input int r);
    return n - r;
  endfunction

  function automatic int sop_pos(input int sym_bw);
    return sym_bw;
  endfunction

  function automatic int eop_pos(input int sym_bw);
    return sym_bw + 1;
  endfunction

  function automatic int abort_pos(input int sym_bw);
    return sym_bw + 2;
  endfunction

  function automatic int entry_width(input int sym_bw);
    return sym_bw + 3;
  endfunction

endpackage

// File: rtl/rs_framer_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy output. A second write
// port lets the framer store an abort marker and a new sop entry in one cycle.
module rs_framer_fifo
  import rs_dec_out_framer_pkg::*;
#(
  parameter int WIDTH = 11,
  parameter int DEPTH = 512
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     wr2_en,
  input  logic [WIDTH-1:0]         wr2_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic [clog2(DEPTH):0]    count
);

  localparam int AW = clog2(DEPTH);

  generate
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $fatal(1, "rs_framer_fifo: DEPTH must be a power of 2 and at least 2");
    end
  endgenerate

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic [AW:0]      wr_ptr_p1;
  logic [1:0]       push_n;
  logic             pop;
  logic [AW+1:0]    after;
  logic             push_ok;

  assign count     = wr_ptr_reg - rd_ptr_reg;
  assign empty     = (count == '0);
  assign pop       = rd_en & ~empty;
  assign push_n    = wr_en ? (wr2_en ? 2'd2 : 2'd1) : 2'd0;
  assign wr_ptr_p1 = wr_ptr_reg + 1'b1;

  // Occupancy after this cycle; a pop frees its slot for a push in the same cycle.
  assign after   = {1'b0, count} + (AW+2)'(push_n) - (AW+2)'(pop);
  assign push_ok = (after <= (AW+2)'(DEPTH));

  assign rd_data = mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(push_n);
      if (pop)     rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && wr_en)           mem[wr_ptr_reg[AW-1:0]] <= wr_data;
    if (push_ok && wr_en && wr2_en) mem[wr_ptr_p1[AW-1:0]]  <= wr2_data;
  end

endmodule

// File: rtl/rs_dec_out_framer.sv
// Strips RS parity from the decoder output stream, frames the data symbols with
// sop/eop and buffers whole frames so the sink can apply backpressure.
module rs_dec_out_framer
  import rs_dec_out_framer_pkg::*;
#(
  parameter int SYM_BW      = 8,
  parameter int N_NUM       = 255,
  parameter int R_NUM       = 16,
  parameter int FIFO_DEPTH  = 512,
  parameter int DROP_CNT_BW = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [SYM_BW-1:0]      symb_out_cnt,
  input  logic                   symb_out_val,
  input  logic [SYM_BW-1:0]      symb_corrected,
  input  logic                   dout_rdy,
  output logic [SYM_BW-1:0]      dout,
  output logic                   dout_val,
  output logic                   dout_sop,
  output logic                   dout_eop,
  output logic                   dout_abort,
  output logic                   frm_drop,
  output logic                   seq_err,
  output logic [DROP_CNT_BW-1:0] drop_cnt
);

  localparam int K_NUM     = k_num(N_NUM, R_NUM);
  localparam int AW        = clog2(FIFO_DEPTH);
  localparam int EW        = entry_width(SYM_BW);
  localparam int SOP_POS   = sop_pos(SYM_BW);
  localparam int EOP_POS   = eop_pos(SYM_BW);
  localparam int ABORT_POS = abort_pos(SYM_BW);
  localparam logic [SYM_BW-1:0] LAST_DATA = SYM_BW'(K_NUM - 1);
  localparam logic [SYM_BW-1:0] LAST_SYM  = SYM_BW'(N_NUM - 1);

  generate
    if (FIFO_DEPTH < K_NUM || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $fatal(1, "rs_dec_out_framer: FIFO_DEPTH must be a power of 2 and >= K_NUM");
    end
    if (SYM_BW < 3 || SYM_BW > 8 || K_NUM < 1 || R_NUM < 0 || N_NUM > (1 << SYM_BW)) begin : g_bad_geom
      $fatal(1, "rs_dec_out_framer: unsupported SYM_BW/N_NUM/R_NUM combination");
    end
  endgenerate

  function automatic logic [EW-1:0] make_entry(input logic abort, input logic eop,
                                               input logic sop, input logic [SYM_BW-1:0] data);
    return {abort, eop, sop, data};
  endfunction

  frm_state_t             state_reg, state_next;
  logic [SYM_BW-1:0]      exp_reg, exp_next;
  logic [1:0]             wr_cnt_reg, wr_cnt_next;
  logic [EW-1:0]          wr0_reg, wr0_next;
  logic [EW-1:0]          wr1_reg, wr1_next;
  logic                   frm_drop_reg, frm_drop_next;
  logic                   seq_err_reg, seq_err_next;
  logic [DROP_CNT_BW-1:0] drop_cnt_reg, drop_cnt_next;

  logic [AW:0]            fifo_count;
  logic [EW-1:0]          fifo_rd_data;
  logic                   fifo_empty;
  logic                   fifo_pop;

  logic                   in_frame;
  logic                   idx_bad;
  logic                   abort_now;
  logic                   start_now;
  logic [AW+2:0]          need;
  logic                   space_ok;
  logic [EW-1:0]          start_entry;

  assign in_frame    = (state_reg != ST_HUNT);
  assign idx_bad     = symb_out_val && in_frame && (symb_out_cnt != exp_reg);
  assign abort_now   = idx_bad && (state_reg == ST_DATA);
  assign start_now   = symb_out_val && (symb_out_cnt == '0) && (!in_frame || idx_bad);
  assign start_entry = make_entry(1'b0, K_NUM == 1, 1'b1, symb_corrected);

  // Entries still in the write register and a same-cycle abort marker are not yet
  // in the FIFO occupancy, so they are reserved on top of the K_NUM frame slots.
  assign need     = (AW+3)'(fifo_count) + (AW+3)'(wr_cnt_reg) + (AW+3)'(abort_now) + (AW+3)'(K_NUM);
  assign space_ok = (need <= (AW+3)'(FIFO_DEPTH));

  always_comb begin
    state_next    = state_reg;
    exp_next      = exp_reg;
    wr_cnt_next   = 2'd0;
    wr0_next      = '0;
    wr1_next      = '0;
    frm_drop_next = 1'b0;
    seq_err_next  = 1'b0;
    drop_cnt_next = drop_cnt_reg;

    if (symb_out_val) begin
      if (idx_bad) begin
        seq_err_next = 1'b1;
        state_next   = ST_HUNT;
        exp_next     = '0;
        if (abort_now) begin
          wr_cnt_next = 2'd1;
          wr0_next    = make_entry(1'b1, 1'b1, 1'b0, '0);
        end
      end else if (in_frame) begin
        if (symb_out_cnt == LAST_SYM) begin
          state_next = ST_HUNT;
          exp_next   = '0;
        end else begin
          exp_next = symb_out_cnt + 1'b1;
          if (state_reg == ST_DATA && symb_out_cnt == LAST_DATA) state_next = ST_PARITY;
        end
        if (state_reg == ST_DATA) begin
          wr_cnt_next = 2'd1;
          wr0_next    = make_entry(1'b0, symb_out_cnt == LAST_DATA, 1'b0, symb_corrected);
        end
      end

      // cnt==0 out of sequence resyncs immediately, behind its abort marker.
      if (start_now) begin
        exp_next = (N_NUM == 1) ? '0 : SYM_BW'(1);
        if (space_ok) begin
          if (K_NUM > 1)      state_next = ST_DATA;
          else if (N_NUM > 1) state_next = ST_PARITY;
          else                state_next = ST_HUNT;
          if (abort_now) begin
            wr_cnt_next = 2'd2;
            wr1_next    = start_entry;
          end else begin
            wr_cnt_next = 2'd1;
            wr0_next    = start_entry;
          end
        end else begin
          state_next    = (N_NUM > 1) ? ST_SKIP : ST_HUNT;
          frm_drop_next = 1'b1;
          if (drop_cnt_reg != {DROP_CNT_BW{1'b1}}) drop_cnt_next = drop_cnt_reg + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_HUNT;
      exp_reg      <= '0;
      wr_cnt_reg   <= 2'd0;
      wr0_reg      <= '0;
      wr1_reg      <= '0;
      frm_drop_reg <= 1'b0;
      seq_err_reg  <= 1'b0;
      drop_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      exp_reg      <= exp_next;
      wr_cnt_reg   <= wr_cnt_next;
      wr0_reg      <= wr0_next;
      wr1_reg      <= wr1_next;
      frm_drop_reg <= frm_drop_next;
      seq_err_reg  <= seq_err_next;
      drop_cnt_reg <= drop_cnt_next;
    end
  end

  rs_framer_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_cnt_reg != 2'd0),
    .wr_data  (wr0_reg),
    .wr2_en   (wr_cnt_reg == 2'd2),
    .wr2_data (wr1_reg),
    .rd_en    (fifo_pop),
    .rd_data  (fifo_rd_data),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign dout_val   = ~fifo_empty;
  assign fifo_pop   = dout_val & dout_rdy;
  assign dout       = dout_val ? fifo_rd_data[SYM_BW-1:0] : '0;
  assign dout_sop   = dout_val & fifo_rd_data[SOP_POS];
  assign dout_eop   = dout_val & fifo_rd_data[EOP_POS];
  assign dout_abort = dout_val & fifo_rd_data[ABORT_POS];
  assign frm_drop   = frm_drop_reg;
  assign seq_err    = seq_err_reg;
  assign drop_cnt   = drop_cnt_reg;

endmodule

// File: tb/tb_rs_dec_out_framer.sv
// Bench for rs_dec_out_framer: scoreboarded stream checks on a 512-deep instance,
// and a 256-deep instance for the whole-frame refusal case.
module tb_rs_dec_out_framer;

  localparam int N = 255;
  localparam int R = 16;
  localparam int K = N - R;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] symb_cnt = '0;
  logic       symb_val = 1'b0;
  logic [7:0] symb_dat = '0;
  logic       rdy_a = 1'b1;
  logic       rdy_b = 1'b1;
  logic       rdy_hold = 1'b1;
  logic       tog_en = 1'b0;

  logic [7:0]  dout_a, dout_b;
  logic        val_a, sop_a, eop_a, abort_a, frm_drop_a, seq_err_a;
  logic        val_b, sop_b, eop_b, abort_b, frm_drop_b, seq_err_b;
  logic [15:0] drop_cnt_a, drop_cnt_b;

  int total = 0;
  int bad = 0;
  int seq_a = 0;
  int drop_a = 0;
  int drop_b = 0;
  int b_cnt = 0;
  logic b_chk = 1'b0;
  logic [10:0] q_a[$];

  always #5 clk = ~clk;

  rs_dec_out_framer #(.SYM_BW(8), .N_NUM(N), .R_NUM(R), .FIFO_DEPTH(512), .DROP_CNT_BW(16)) dut_a (
    .clk(clk), .rst(rst), .symb_out_cnt(symb_cnt), .symb_out_val(symb_val),
    .symb_corrected(symb_dat), .dout_rdy(rdy_a), .dout(dout_a), .dout_val(val_a),
    .dout_sop(sop_a), .dout_eop(eop_a), .dout_abort(abort_a), .frm_drop(frm_drop_a),
    .seq_err(seq_err_a), .drop_cnt(drop_cnt_a));

  rs_dec_out_framer #(.SYM_BW(8), .N_NUM(N), .R_NUM(R), .FIFO_DEPTH(256), .DROP_CNT_BW(16)) dut_b (
    .clk(clk), .rst(rst), .symb_out_cnt(symb_cnt), .symb_out_val(symb_val),
    .symb_corrected(symb_dat), .dout_rdy(rdy_b), .dout(dout_b), .dout_val(val_b),
    .dout_sop(sop_b), .dout_eop(eop_b), .dout_abort(abort_b), .frm_drop(frm_drop_b),
    .seq_err(seq_err_b), .drop_cnt(drop_cnt_b));

  function automatic logic [10:0] mk(input logic a, input logic e, input logic s, input logic [7:0] d);
    return {a, e, s, d};
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input int c, input int d);
    symb_val = v;
    symb_cnt = 8'(c);
    symb_dat = 8'(d);
    @(posedge clk);
    #1;
    symb_val = 1'b0;
  endtask

  task automatic send_cw(input int first, input int last, input int salt, input bit push);
    for (int c = first; c <= last; c++) begin
      logic [7:0] d;
      d = 8'((c + salt) & 255);
      if (push && c < K) q_a.push_back(mk(1'b0, c == K - 1, c == 0, d));
      drive(1'b1, c, d);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 0, 0);
  endtask

  task automatic wait_drain(input int max_cyc);
    int n;
    n = 0;
    while ((q_a.size() != 0 || val_a) && n < max_cyc) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_queue_left", q_a.size(), 0);
  endtask

  // Drives dout_rdy of the main instance: toggling every cycle or held at rdy_hold.
  initial forever begin
    @(posedge clk);
    #1;
    if (tog_en) rdy_a = ~rdy_a;
    else        rdy_a = rdy_hold;
  end

  // Scoreboard and stall-stability monitor for the main instance.
  initial begin
    logic        hold_valid;
    logic [10:0] hold_word;
    logic [10:0] exp_w;
    hold_valid = 1'b0;
    hold_word  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_valid = 1'b0;
      end else begin
        if (hold_valid && val_a) begin
          total++;
          if ({abort_a, eop_a, sop_a, dout_a} != hold_word) begin
            bad++;
            $display("FAIL stall_hold: got %0h expected %0h", {abort_a, eop_a, sop_a, dout_a}, hold_word);
          end
        end
        hold_valid = val_a && !rdy_a;
        hold_word  = {abort_a, eop_a, sop_a, dout_a};
        if (val_a && rdy_a) begin
          total++;
          if (q_a.size() == 0) begin
            bad++;
            $display("FAIL sb_unexpected: got %0h expected no output", {abort_a, eop_a, sop_a, dout_a});
          end else begin
            exp_w = q_a.pop_front();
            if ({abort_a, eop_a, sop_a, dout_a} != exp_w) begin
              bad++;
              $display("FAIL sb_entry: got %0h expected %0h", {abort_a, eop_a, sop_a, dout_a}, exp_w);
            end
          end
        end
        if (seq_err_a)  seq_a++;
        if (frm_drop_a) drop_a++;
        if (frm_drop_b) drop_b++;
        if (b_chk && val_b && rdy_b) begin
          total++;
          exp_w = mk(1'b0, b_cnt == K - 1, b_cnt == 0, 8'(b_cnt));
          if ({abort_b, eop_b, sop_b, dout_b} != exp_w) begin
            bad++;
            $display("FAIL b_entry: got %0h expected %0h", {abort_b, eop_b, sop_b, dout_b}, exp_w);
          end
          b_cnt++;
        end
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int   n_good;
    int   bad_cnt;
    logic exp_seq;
  } vec_t;

  initial begin
    vec_t vecs[5];
    int   seq_before;

    vecs[0] = '{100, 150, 1'b1};  // jump inside DATA
    vecs[1] = '{120, 0,   1'b1};  // cnt 0 at expected 120: abort then resync
    vecs[2] = '{245, 7,   1'b1};  // break in PARITY, frame already complete
    vecs[3] = '{10,  9,   1'b1};  // backwards step in DATA
    vecs[4] = '{255, 5,   1'b0};  // stray index while hunting is ignored

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_a", {dout_a, val_a, sop_a, eop_a, abort_a, frm_drop_a, seq_err_a, drop_cnt_a}, 0);
    check("reset_out_b", {dout_b, val_b, sop_b, eop_b, abort_b, frm_drop_b, seq_err_b, drop_cnt_b}, 0);
    rst = 1'b0;
    idle(2);

    // Single codeword, first output two cycles after cnt 0
    q_a.push_back(mk(1'b0, 1'b0, 1'b1, 8'd0));
    drive(1'b1, 0, 0);
    check("latency_t1_val", val_a, 0);
    q_a.push_back(mk(1'b0, 1'b0, 1'b0, 8'd1));
    drive(1'b1, 1, 1);
    check("latency_t2_val", val_a, 1);
    check("latency_t2_sop", {sop_a, dout_a}, {1'b1, 8'd0});
    send_cw(2, N - 1, 0, 1'b1);
    wait_drain(400);

    // Three back-to-back codewords with dout_rdy toggling
    tog_en = 1'b1;
    for (int f = 0; f < 3; f++) send_cw(0, N - 1, 11 * (f + 1), 1'b1);
    wait_drain(3000);
    tog_en   = 1'b0;
    rdy_hold = 1'b1;
    idle(2);
    check("b2b_no_drop", drop_a, 0);

    // Sequence-break table
    for (int i = 0; i < 5; i++) begin
      seq_before = seq_a;
      for (int c = 0; c < vecs[i].n_good; c++) begin
        if (c < K) q_a.push_back(mk(1'b0, c == K - 1, c == 0, 8'(c)));
        drive(1'b1, c, c);
      end
      if (vecs[i].exp_seq && vecs[i].n_good < K) q_a.push_back(mk(1'b1, 1'b1, 1'b0, 8'd0));
      if (vecs[i].exp_seq && vecs[i].bad_cnt == 0) q_a.push_back(mk(1'b0, 1'b0, 1'b1, 8'd0));
      drive(1'b1, vecs[i].bad_cnt, vecs[i].bad_cnt);
      check($sformatf("row%0d_seq_pulse", i), seq_err_a, vecs[i].exp_seq);
      idle(1);
      check($sformatf("row%0d_seq_width", i), seq_err_a, 0);
      if (vecs[i].exp_seq && vecs[i].bad_cnt == 0) send_cw(1, N - 1, 0, 1'b1);
      idle(5);
      send_cw(0, N - 1, 3 * i + 1, 1'b1);
      wait_drain(600);
      check($sformatf("row%0d_seq_count", i), seq_a - seq_before, int'(vecs[i].exp_seq));
    end

    // Whole-frame refusal on the 256-deep instance
    rst = 1'b1;
    q_a.delete();
    idle(2);
    rst   = 1'b0;
    rdy_b = 1'b0;
    drop_b = 0;
    b_cnt = 0;
    b_chk = 1'b1;
    idle(1);
    send_cw(0, N - 1, 0, 1'b1);
    send_cw(0, N - 1, 0, 1'b1);
    idle(3);
    check("refuse_pulses_b", drop_b, 1);
    check("refuse_cnt_b", drop_cnt_b, 1);
    check("refuse_val_b", val_b, 1);
    check("refuse_cnt_a", drop_cnt_a, 0);
    rdy_b = 1'b1;
    idle(300);
    check("refuse_out_cnt_b", b_cnt, K);
    b_chk = 1'b0;
    wait_drain(200);

    // Reset mid-frame with 50 entries buffered
    rdy_hold = 1'b0;
    idle(1);
    send_cw(0, 49, 0, 1'b0);
    idle(2);
    check("midrst_pre_val", val_a, 1);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_val_a", val_a, 0);
    check("midrst_drop_b", drop_cnt_b, 0);
    q_a.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    rdy_hold = 1'b1;
    idle(2);
    send_cw(0, N - 1, 77, 1'b1);
    wait_drain(400);
    check("final_no_drop_a", drop_a, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
